sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//  Serial-to-parallel receive stage directly downstream of the PISO shifter.
//  Samples the serial bit stream on bit strobes and assembles DATA_WIDTH-bit
//  words, MSB received first. Presents each word on a valid/ready output
//  register. Flags overrun when the consumer stalls.
// PARAMETERS
//  DATA_WIDTH  4  word width in bits; legal range >= 2
//  MSB_FIRST   1  1: first received bit lands in data[DATA_WIDTH-1]; 0: in data[0]
// PORTS
//  clk             in   1           single clock, rising edge
//  rst             in   1           synchronous, active-high reset
//  serial_in       in   1           serial data bit (PISO q_out)
//  bit_valid_in    in   1           strobe: serial_in is sampled this cycle
//  start_in        in   1           frame start; qualified by bit_valid_in
//  m_data          out  DATA_WIDTH  assembled word
//  m_valid         out  1           m_data holds an unconsumed word
//  m_ready         in   1           consumer accepts word when m_valid&&m_ready
//  busy_out        out  1           1 while in SHIFT state
//  overrun_out     out  1           sticky: completed word dropped
//  parity_err_out  out  1           sticky: parity mismatch (see CONFIGURATION)
//  clr_flags_in    in   1           clears overrun_out and parity_err_out
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, bit count=0, shift reg=0, m_data=0,
//   m_valid=0, busy_out=0, overrun_out=0, parity_err_out=0. Overrides all inputs;
//   a partial word in progress is discarded.
//  FSM IDLE: bit_valid_in && start_in -> sample serial_in as bit 0, count=1,
//   go SHIFT. bit_valid_in without start_in is ignored.
//  FSM SHIFT: each bit_valid_in samples serial_in and increments count.
//   Cycles with bit_valid_in=0 hold all state; no timeout.
//   When the last frame bit is sampled -> word complete, return to IDLE.
//  start_in && bit_valid_in in SHIFT: partial word discarded, no flag raised;
//   this bit becomes bit 0 of a new frame (count=1), stays SHIFT.
//  Frame length is DATA_WIDTH bits; DATA_WIDTH+1 with PARITY_EN.
//  Word complete: if m_valid=0, or m_valid&&m_ready in the same cycle, load
//   m_data and set m_valid=1 at that edge.
//   Otherwise the new word is dropped, m_data unchanged, and overrun_out is set.
//  Latency: m_valid rises on the clk edge that samples the last frame bit.
//   A back-to-back start in the next cycle is accepted (no dead cycle).
//  m_valid&&m_ready with no word completing: m_valid cleared next edge.
//  m_data is stable while m_valid=1 and m_ready=0.
//  clr_flags_in clears both sticky flags.
//   If a flag-setting event occurs in the same cycle, set wins.
//  busy_out = (state==SHIFT), registered.
// CONFIGURATION
//  Macro SIPO_PARITY_EN:
//   defined: frame carries one extra trailing bit = even parity of data bits.
//    On mismatch the word is dropped (m_valid unaffected) and parity_err_out set.
//    Overrun is not flagged for a parity-failed word.
//   undefined: frame = DATA_WIDTH bits; parity_err_out tied 0; no parity logic.
// TESTING (DATA_WIDTH=4, MSB_FIRST=1 unless noted)
//  1. start+bits 1,0,1,1 with m_ready=1 -> m_data=4'hB, m_valid 1 for one cycle.
//  2. Gaps: bits 0,1,1,0 with 3 idle cycles between strobes -> m_data=4'h6.
//     busy_out=1 throughout the frame.
//  3. m_ready=0: frames 4'hA then 4'h5 -> m_data stays 4'hA, overrun_out=1.
//     clr_flags_in -> overrun_out=0.
//  4. start mid-frame after 2 bits, then 1,1,1,1 -> m_data=4'hF, no flags.
//     MSB_FIRST=0 with bits 1,0,0,0 -> m_data=4'h1.
//  5. rst asserted after 3 bits -> all outputs 0 next edge.
//     A following full frame 4'h9 is received correctly.
//  6. SIPO_PARITY_EN: 4'hB+parity 1 -> delivered.
//     4'hB+parity 0 -> no m_valid, parity_err_out=1.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Serial-in and word-out signal bundle for sipo_deserializer.
// master = deserializer side, slave = serial source / word consumer side.
interface sipo_deserializer_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  serial_in;
  logic                  bit_valid_in;
  logic                  start_in;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  busy_out;
  logic                  overrun_out;
  logic                  parity_err_out;
  logic                  clr_flags_in;

  modport master (
    input  serial_in, bit_valid_in, start_in, m_ready, clr_flags_in,
    output m_data, m_valid, busy_out, overrun_out, parity_err_out
  );

  modport slave (
    output serial_in, bit_valid_in, start_in, m_ready, clr_flags_in,
    input  m_data, m_valid, busy_out, overrun_out, parity_err_out
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Assembles strobed serial bits into DATA_WIDTH-bit words; optional even-parity bit via SIPO_PARITY_EN.
// Latency: m_valid rises on the edge sampling the last frame bit; back-to-back frames need no dead cycle.
// Backpressure: one-word output register; a word completing while it is full and unread is dropped (overrun).
module sipo_deserializer #(
  parameter int DATA_WIDTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sipo_deserializer_if.master  bus
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, nxt_state;
  logic [CNT_W-1:0]      cnt, nxt_cnt;
  logic [DATA_WIDTH-1:0] shreg, nxt_shreg;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_done;
  logic                  parity_ok;
  logic                  good_word;
  logic                  deliver;
  logic                  drop;

  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  busy_q;
  logic                  overrun_q;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] base,
                                                     input logic b);
    if (MSB_FIRST != 0) return {base[DATA_WIDTH-2:0], b};
    else                return {b, base[DATA_WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      shreg <= nxt_shreg;
    end
  end

  // A start strobe always opens a fresh frame, even mid-frame.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_shreg = shreg;
    word_done = 1'b0;
    word      = shreg;
    parity_ok = 1'b1;
    if (bus.bit_valid_in) begin
      if (bus.start_in) begin
        nxt_state = SHIFT;
        nxt_cnt   = CNT_W'(1);
        nxt_shreg = shift_in('0, bus.serial_in);
      end else if (state == SHIFT) begin
        if (cnt == CNT_W'(FRAME_LEN - 1)) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
          nxt_shreg = '0;
          word_done = 1'b1;
`ifdef SIPO_PARITY_EN
          word      = shreg;
          parity_ok = ((^shreg) == bus.serial_in);
`else
          word      = shift_in(shreg, bus.serial_in);
`endif
        end else begin
          nxt_cnt   = cnt + CNT_W'(1);
          nxt_shreg = shift_in(shreg, bus.serial_in);
        end
      end
    end
  end

  assign good_word = word_done && parity_ok;
  assign deliver   = good_word && (!m_valid_q || bus.m_ready);
  assign drop      = good_word && m_valid_q && !bus.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (deliver) begin
        m_data_q  <= word;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
      busy_q    <= (nxt_state == SHIFT);
      overrun_q <= drop || (overrun_q && !bus.clr_flags_in);
    end
  end

`ifdef SIPO_PARITY_EN
  logic parity_err_q;
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= (word_done && !parity_ok) || (parity_err_q && !bus.clr_flags_in);
  end
  assign bus.parity_err_out = parity_err_q;
`else
  assign bus.parity_err_out = 1'b0;
`endif

  assign bus.m_data      = m_data_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.busy_out    = busy_q;
  assign bus.overrun_out = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first DUT plus an LSB-first DUT sharing the stimulus.
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sipo_deserializer_if #(.DATA_WIDTH(4)) bus ();
  sipo_deserializer_if #(.DATA_WIDTH(4)) bus2 ();

  sipo_deserializer #(.DATA_WIDTH(4), .MSB_FIRST(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  sipo_deserializer #(.DATA_WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  assign bus2.serial_in    = bus.serial_in;
  assign bus2.bit_valid_in = bus.bit_valid_in;
  assign bus2.start_in     = bus.start_in;
  assign bus2.m_ready      = bus.m_ready;
  assign bus2.clr_flags_in = bus.clr_flags_in;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    bus.serial_in    = b;
    bus.bit_valid_in = 1'b1;
    bus.start_in     = st;
    tick();
    bus.bit_valid_in = 1'b0;
    bus.start_in     = 1'b0;
    bus.serial_in    = 1'b0;
  endtask

  // Sends w MSB first (plus even parity when enabled), with gap idle cycles between strobes.
  task automatic send_frame(input logic [3:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i], i == 3);
      if (i != 0 || `ifdef SIPO_PARITY_EN 1 `else 0 `endif)
        for (int g = 0; g < gap; g++) tick();
    end
`ifdef SIPO_PARITY_EN
    send_bit(^w, 1'b0);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
    n_tests++; if (bus.m_data !== 4'h0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", bus.m_data); end
    n_tests++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy_out); end
    n_tests++; if (bus.overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun_out); end
    n_tests++; if (bus.parity_err_out !== 1'b0) begin n_fail++; $display("FAIL reset_parity got %b want 0", bus.parity_err_out); end
  endtask

  task automatic test_basic();
    bus.m_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    n_tests++; if (bus.busy_out !== 1'b1) begin n_fail++; $display("FAIL basic_busy_first got %b want 1", bus.busy_out); end
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", bus.m_valid); end
    send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b1, 1'b0);
`endif
    n_tests++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.m_valid); end
    n_tests++; if (bus.m_data !== 4'hB) begin n_fail++; $display("FAIL basic_data got %h want b", bus.m_data); end
    n_tests++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", bus.busy_out); end
    tick();
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %b want 0", bus.m_valid); end
  endtask

  task automatic test_gaps();
    int busy_bad = 0;
    bus.m_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < 3; g++) begin
        if (bus.busy_out !== 1'b1 || bus.m_valid !== 1'b0) busy_bad++;
        tick();
      end
      send_bit(i != 2, 1'b0);
    end
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    n_tests++; if (busy_bad != 0) begin n_fail++; $display("FAIL gaps_busy_hold got %0d bad cycles want 0", busy_bad); end
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 4'h6) begin
      n_fail++; $display("FAIL gaps_word got v=%b d=%h want v=1 d=6", bus.m_valid, bus.m_data); end
    tick();
  endtask

  task automatic test_overrun();
    bus.m_ready = 1'b0;
    send_frame(4'hA, 0);
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 4'hA) begin
      n_fail++; $display("FAIL ovr_first got v=%b d=%h want v=1 d=a", bus.m_valid, bus.m_data); end
    n_tests++; if (bus.overrun_out !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %b want 0", bus.overrun_out); end
    send_frame(4'h5, 0);
    n_tests++; if (bus.m_data !== 4'hA || bus.m_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovr_hold got v=%b d=%h want v=1 d=a", bus.m_valid, bus.m_data); end
    n_tests++; if (bus.overrun_out !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", bus.overrun_out); end
    tick();
    n_tests++; if (bus.overrun_out !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", bus.overrun_out); end
    bus.clr_flags_in = 1'b1;
    tick();
    bus.clr_flags_in = 1'b0;
    n_tests++; if (bus.overrun_out !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", bus.overrun_out); end
    bus.m_ready = 1'b1;
    tick();
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume got %b want 0", bus.m_valid); end
  endtask

  task automatic test_restart();
    bus.m_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_frame(4'hF, 0);
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 4'hF) begin
      n_fail++; $display("FAIL restart_word got v=%b d=%h want v=1 d=f", bus.m_valid, bus.m_data); end
    n_tests++; if (bus.overrun_out !== 1'b0 || bus.parity_err_out !== 1'b0) begin
      n_fail++; $display("FAIL restart_flags got o=%b p=%b want 0 0", bus.overrun_out, bus.parity_err_out); end
    tick();
  endtask

  task automatic test_lsb_first();
    bus.m_ready = 1'b1;
    send_frame(4'h8, 0);
    n_tests++; if (bus2.m_valid !== 1'b1 || bus2.m_data !== 4'h1) begin
      n_fail++; $display("FAIL lsb_word got v=%b d=%h want v=1 d=1", bus2.m_valid, bus2.m_data); end
    n_tests++; if (bus.m_data !== 4'h8) begin n_fail++; $display("FAIL msb_word got %h want 8", bus.m_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b0;
    send_frame(4'h6, 0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (bus.m_valid !== 1'b0 || bus.m_data !== 4'h0 || bus.busy_out !== 1'b0 || bus.overrun_out !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs got v=%b d=%h b=%b o=%b want all 0",
                         bus.m_valid, bus.m_data, bus.busy_out, bus.overrun_out); end
    bus.m_ready = 1'b1;
    send_frame(4'h9, 0);
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 4'h9) begin
      n_fail++; $display("FAIL midrst_next got v=%b d=%h want v=1 d=9", bus.m_valid, bus.m_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.m_ready = 1'b1;
    send_frame(4'h3, 0);
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 4'h3) begin
      n_fail++; $display("FAIL b2b_first got v=%b d=%h want v=1 d=3", bus.m_valid, bus.m_data); end
    send_frame(4'hC, 0);
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 4'hC || bus.overrun_out !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second got v=%b d=%h o=%b want v=1 d=c o=0",
                         bus.m_valid, bus.m_data, bus.overrun_out); end
    tick();
  endtask

  task automatic test_parity();
    bus.m_ready = 1'b1;
`ifdef SIPO_PARITY_EN
    send_frame(4'hB, 0);
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 4'hB || bus.parity_err_out !== 1'b0) begin
      n_fail++; $display("FAIL par_good got v=%b d=%h p=%b want v=1 d=b p=0",
                         bus.m_valid, bus.m_data, bus.parity_err_out); end
    tick();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    n_tests++; if (bus.m_valid !== 1'b0 || bus.parity_err_out !== 1'b1 || bus.overrun_out !== 1'b0) begin
      n_fail++; $display("FAIL par_bad got v=%b p=%b o=%b want v=0 p=1 o=0",
                         bus.m_valid, bus.parity_err_out, bus.overrun_out); end
    bus.clr_flags_in = 1'b1;
    tick();
    bus.clr_flags_in = 1'b0;
    n_tests++; if (bus.parity_err_out !== 1'b0) begin n_fail++; $display("FAIL par_clear got %b want 0", bus.parity_err_out); end
`else
    send_frame(4'hB, 0);
    n_tests++; if (bus.parity_err_out !== 1'b0 || bus.m_data !== 4'hB) begin
      n_fail++; $display("FAIL par_off got p=%b d=%h want p=0 d=b", bus.parity_err_out, bus.m_data); end
    tick();
`endif
  endtask

  initial begin
    bus.serial_in    = 1'b0;
    bus.bit_valid_in = 1'b0;
    bus.start_in     = 1'b0;
    bus.m_ready      = 1'b0;
    bus.clr_flags_in = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_restart();
    test_lsb_first();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
